div_ctrl: RTL and testbench

//   Multi-cycle sequencer for the RV32M divide group (DIV/DIVU/REM/REMU).
//   The execute stage detects a divide and pulses start_i. This block runs a 32-step restoring divider.

---
 rtl/div_ctrl.sv | 131 +++++++++++++
 tb/tb_div_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle sequencer for the RV32M divide group (DIV/DIVU/REM/REMU).
// Runs a DW-step restoring divider on operand magnitudes and fixes up signs on completion.
module div_ctrl #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [2:0]    func3_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          ready_o,
    output logic [DW-1:0] result_o,
    output logic [4:0]    rd_addr_o,
    output logic          reg_wen_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rem_sel_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [DW-1:0]    dvs_q;
    logic [DW-1:0]    quo_q;
    logic [DW-1:0]    rem_q;
    logic [DW-1:0]    result_q;
    logic [4:0]       rd_addr_q;

    logic          accept;
    logic          is_signed;
    logic          dvd_neg;
    logic          dvs_neg;
    logic          div_zero;
    logic          last;
    logic [DW-1:0] dvd_abs;
    logic [DW-1:0] dvs_abs;
    logic [DW-1:0] zero_res;

    logic [DW:0]   rem_sh;
    logic [DW-1:0] quo_sh;
    logic [DW-1:0] diff;
    logic          ge;
    logic [DW-1:0] rem_step;
    logic [DW-1:0] quo_step;
    logic [DW-1:0] quo_fin;
    logic [DW-1:0] rem_fin;
    logic [DW-1:0] fin;

    assign accept    = (state_q == IDLE) && start_i && !flush_i;
    assign is_signed = func3_i[2] && !func3_i[0];
    assign dvd_neg   = is_signed && dividend_i[DW-1];
    assign dvs_neg   = is_signed && divisor_i[DW-1];
    assign dvd_abs   = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign dvs_abs   = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign zero_res  = func3_i[1] ? dividend_i : '1;
    assign last      = (cnt_q == CNT_W'(DW - 1));

    // rem_sh is the DW+1 bit partial remainder; its top bit alone means it exceeds any divisor,
    // and the modular DW-bit difference is exact because the result is always below the divisor.
    assign rem_sh   = {rem_q, quo_q[DW-1]};
    assign quo_sh   = {quo_q[DW-2:0], 1'b0};
    assign ge       = rem_sh[DW] || (rem_sh[DW-1:0] >= dvs_q);
    assign diff     = rem_sh[DW-1:0] - dvs_q;
    assign rem_step = ge ? diff : rem_sh[DW-1:0];
    assign quo_step = quo_sh | {{(DW-1){1'b0}}, ge};

    assign quo_fin = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    assign rem_fin = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
    assign fin     = rem_sel_q ? rem_fin : quo_fin;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = div_zero ? DONE : CALC;
            CALC:    if (flush_i) state_d = IDLE;
                     else if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rem_sel_q <= func3_i[1];
                rd_addr_q <= rd_addr_i;
                neg_quo_q <= dvd_neg ^ dvs_neg;
                neg_rem_q <= dvd_neg;
                dvs_q     <= dvs_abs;
                quo_q     <= dvd_abs;
                rem_q     <= '0;
                cnt_q     <= '0;
                if (div_zero) result_q <= zero_res;
            end else if (state_q == CALC && !flush_i) begin
                quo_q <= quo_step;
                rem_q <= rem_step;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last) result_q <= fin;
            end
        end
    end

    // A flush landing on the DONE cycle suppresses the write-back.
    assign busy_o    = accept || (state_q == CALC);
    assign ready_o   = (state_q == DONE) && !flush_i;
    assign reg_wen_o = ready_o;
    assign result_o  = result_q;
    assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomised scoreboard bench for div_ctrl: stimulus pushes expected write-backs,
// a monitor pops and compares them whenever ready_o pulses.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy;
    logic        ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wen;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;

    div_ctrl #(.DW(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .func3_i    (func3),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .rd_addr_i  (rd_addr),
        .flush_i    (flush),
        .busy_o     (busy),
        .ready_o    (ready),
        .result_o   (result),
        .rd_addr_o  (rd_out),
        .reg_wen_o  (wen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return f3[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst === 1'b0) begin
            chk("reg_wen_eq_ready", 32'(wen), 32'(ready));
            if (ready === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_ready", 32'(ready), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("rd_addr", 32'(rd_out), 32'(e.rd));
                    chk("ready_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_drain(input int bound);
        int n;
        for (n = 0; n < bound; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #2;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    // Issue one op; optionally re-pulse start with other operands restart_at cycles later.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int restart_at);
        int          busy_n;
        int unsigned lat;
        int          n;
        @(negedge clk);
        start    = 1'b1;
        func3    = f3;
        dividend = a;
        divisor  = b;
        rd_addr  = rd;
        lat      = (b == 32'd0) ? 1 : 33;
        q.push_back('{rd, model(f3, a, b), cyc + lat});
        #2;
        busy_n = busy ? 1 : 0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            start    = (n + 1 == restart_at);
            func3    = 3'd4 + 3'($urandom_range(0, 3));
            dividend = $urandom;
            divisor  = $urandom;
            rd_addr  = 5'($urandom);
            #2;
            if (busy) busy_n++;
            if (q.size() == 0) break;
        end
        start = 1'b0;
        if (q.size() != 0) begin
            chk("ready_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        chk("busy_cycles", 32'(busy_n), 32'(lat == 1 ? 1 : 33));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        func3 = 3'd4; dividend = '0; divisor = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        rst = 1'b0;

        run_op(3'b101, 32'd100, 32'd7, 5'd3, 0);
        run_op(3'b111, 32'd100, 32'd7, 5'd4, 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
        run_op(3'b101, 32'd5, 32'd0, 5'd9, 0);
        run_op(3'b110, 32'hFFFF_FFF0, 32'd0, 5'd10, 0);
        run_op(3'b101, 32'd77, 32'd5, 5'd0, 0);
        run_op(3'b100, 32'd1000, 32'hFFFF_FFFD, 5'd11, 5);

        // Flush mid-calculation: no write-back, busy drops the following cycle.
        @(negedge clk);
        start = 1'b1; func3 = 3'b100; dividend = 32'd50; divisor = 32'd5; rd_addr = 5'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        chk("flush_busy_after", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        run_op(3'b101, 32'd9, 32'd3, 5'd13, 0);

        // Start held through the DONE cycle is taken on the following IDLE cycle.
        @(negedge clk);
        start = 1'b1; func3 = 3'b111; dividend = 32'd123; divisor = 32'd0; rd_addr = 5'd14;
        q.push_back('{5'd14, model(3'b111, 32'd123, 32'd0), cyc + 1});
        @(negedge clk);
        func3 = 3'b101; dividend = 32'd9; divisor = 32'd3; rd_addr = 5'd15;
        q.push_back('{5'd15, model(3'b101, 32'd9, 32'd3), cyc + 34});
        #2;
        chk("done_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2;
        chk("idle_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        #2;
        wait_drain(60);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func3 = 3'b101; dividend = 32'd8; divisor = 32'd2;
        #2;
        chk("start_flush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #2;
        chk("start_flush_idle", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);

        // Reset mid-op discards everything, including the held result.
        @(negedge clk);
        start = 1'b1; func3 = 3'b100; dividend = 32'd999; divisor = 32'd7; rd_addr = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd", 32'(rd_out), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'd4 + 3'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 1) begin
                b = 32'd0;
            end else if (sel == 2) begin
                a = 32'($urandom_range(0, 200));
                b = 32'($urandom_range(1, 15));
            end else if (sel == 3) begin
                b = 32'($signed(-$urandom_range(1, 9)));
            end
            run_op(f3, a, b, 5'($urandom), 0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
